// File: rtl/ast_pkg.sv
// Shared constants and helpers for the access scheduler tree.
package ast_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int num_req(input int switch_bits);
    return 1 << switch_bits;
  endfunction

  function automatic int num_nodes(input int switch_bits);
    return (1 << switch_bits) - 1;
  endfunction

  localparam int DEF_SWITCH_BITS = 3;
  localparam int DEF_N           = num_req(DEF_SWITCH_BITS);
  localparam int DEF_NODES       = num_nodes(DEF_SWITCH_BITS);
  localparam int DEF_IDX_W       = clog2(DEF_N);

endpackage

// File: rtl/ast_node.sv
// Two-input arbitration node: ORs child activity and picks a side using one priority flop.
module ast_node
  import ast_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic act_lo,
  input  logic act_hi,
  input  logic upd_en,
  input  logic taken,
  output logic active,
  output logic sel
);

  logic pri_q;
  logic pri_d;

  assign active = act_lo | act_hi;
  // Priority only matters when both sides compete.
  assign sel    = (act_lo && act_hi) ? pri_q : act_hi;

  always_comb begin
    pri_d = pri_q;
    if (upd_en && act_lo && act_hi) begin
      pri_d = ~taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/access_sched_tree.sv
// Tree arbiter with burst lock and a single registered output slot (full throughput).
module access_sched_tree
  import ast_pkg::*;
#(
  parameter int SWITCH_BITS = 3,
  parameter int DATA_WIDTH  = 132
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [(2**SWITCH_BITS)-1:0]              req,
  input  logic [(2**SWITCH_BITS)-1:0]              req_last,
  input  logic [(2**SWITCH_BITS)*DATA_WIDTH-1:0]   d_in,
  output logic [(2**SWITCH_BITS)-1:0]              grant,
  output logic [DATA_WIDTH-1:0]                    d_out,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [SWITCH_BITS-1:0]                   out_src,
  output logic                                     active
);

  localparam int N = num_req(SWITCH_BITS);

  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  d_out_q, d_out_d;
  logic [SWITCH_BITS-1:0] out_src_q, out_src_d;
  logic                   lock_q, lock_d;
  logic [SWITCH_BITS-1:0] lock_idx_q, lock_idx_d;

  logic [N-1:0]           tree_oh;
  logic [SWITCH_BITS-1:0] tree_win;
  logic [SWITCH_BITS-1:0] winner;
  logic                   win_valid;
  logic                   cap;
  logic                   upd;

  // Level gl holds 2**gl entries; the deepest level is the requesters themselves.
  genvar gl, gi;
  generate
    for (gl = 0; gl <= SWITCH_BITS; gl++) begin : g_lvl
      localparam int W = 1 << gl;
      logic [W-1:0] act_l;
      logic [W-1:0] path_l;

      if (gl == SWITCH_BITS) begin : g_leaf
        assign act_l = req;
      end else begin : g_int
        for (gi = 0; gi < W; gi++) begin : g_node
          logic sel_w;
          logic on_path;
          assign on_path = ((winner >> (SWITCH_BITS - gl)) == SWITCH_BITS'(gi));
          ast_node u_node (
            .clk    (clk),
            .rst    (rst),
            .act_lo (g_lvl[gl+1].act_l[2*gi]),
            .act_hi (g_lvl[gl+1].act_l[2*gi+1]),
            .upd_en (upd && on_path),
            .taken  (winner[SWITCH_BITS-1-gl]),
            .active (act_l[gi]),
            .sel    (sel_w)
          );
        end
      end

      if (gl == 0) begin : g_root
        assign path_l = 1'b1;
      end else begin : g_path
        for (gi = 0; gi < W; gi++) begin : g_bit
          assign path_l[gi] = g_lvl[gl-1].path_l[gi/2] &
                              (g_lvl[gl-1].g_int.g_node[gi/2].sel_w == 1'(gi % 2));
        end
      end
    end
  endgenerate

  assign tree_oh = g_lvl[SWITCH_BITS].path_l;

  always_comb begin
    tree_win = '0;
    for (int i = 0; i < N; i++) begin
      if (tree_oh[i]) begin
        tree_win = SWITCH_BITS'(i);
      end
    end
  end

  // A locked burst overrides the tree; a stalled lock holder blocks everyone.
  assign win_valid = lock_q ? req[lock_idx_q] : g_lvl[0].act_l[0];
  assign winner    = lock_q ? lock_idx_q : tree_win;
  assign cap       = !rst && win_valid && (!out_valid_q || out_ready);
  assign upd       = cap && req_last[winner];

  always_comb begin
    grant = '0;
    if (cap) begin
      grant[winner] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    d_out_d     = d_out_q;
    out_src_d   = out_src_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    if (cap) begin
      out_valid_d = 1'b1;
      d_out_d     = d_in[winner*DATA_WIDTH +: DATA_WIDTH];
      out_src_d   = winner;
      lock_d      = !req_last[winner];
      lock_idx_d  = winner;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      out_src_q   <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      d_out_q     <= d_out_d;
      out_src_q   <= out_src_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d_out     = d_out_q;
  assign out_src   = out_src_q;
  assign active    = |req;

endmodule

// File: doc/access_sched_tree.md
ACCESS_SCHED_TREE -- requirements
Module: access_sched_tree

Interface
REQ-001 SHALL have parameter SWITCH_BITS, default 3, log2 of requester count N = 2**SWITCH_BITS (legal 1..5).
REQ-002 SHALL have parameter DATA_WIDTH, default 132, width of each requester payload.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req, input, N, per-requester valid.
REQ-006 SHALL have port req_last, input, N, marks final beat of a requester's burst.
REQ-007 SHALL have port d_in, input, N*DATA_WIDTH, payloads, requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port grant, output, N, one-hot capture acknowledge, combinational.
REQ-009 SHALL have port d_out, output, DATA_WIDTH, registered winning payload.
REQ-010 SHALL have port out_valid, output, 1, d_out holds an untaken beat.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts d_out.
REQ-012 SHALL have port out_src, output, SWITCH_BITS, registered index of requester that produced d_out.
REQ-013 SHALL have port active, output, 1, OR of req (combinational).

Function
REQ-014 Capture condition cap = (|req) && (!out_valid || out_ready); capture loads d_out, out_src, sets out_valid the same edge.
REQ-015 grant[i] SHALL be 1 only in a cycle where cap=1 and i is the winner; at most one bit set; zero when cap=0.
REQ-016 Latency: req asserted cycle t with empty output -> grant in t, out_valid/d_out valid in t+1.
REQ-017 out_valid SHALL clear on out_ready when no capture occurs that cycle; simultaneous drain and capture keeps out_valid=1 with new data (full throughput, 1 beat/cycle).
REQ-018 d_out/out_src SHALL hold stable while out_valid && !out_ready.
REQ-019 Arbitration: binary tree of SWITCH_BITS levels, 2**SWITCH_BITS-1 nodes; node active = OR of child actives; each node holds one priority flop pri (0 favours lower-index subtree).
REQ-020 A node with exactly one active child SHALL select that child regardless of pri.
REQ-021 A node with both children active SHALL select child pri.
REQ-022 On a capture with req_last[winner]=1, every node on the winner's path that had both children active SHALL set pri to the non-selected side; other nodes unchanged.
REQ-023 Burst lock: on capture with req_last[winner]=0, lock SHALL set with lock_idx=winner; while locked, only lock_idx may win, all other grants forced 0, pri frozen.
REQ-024 Lock SHALL clear on capture of lock_idx with req_last=1; if req[lock_idx] drops while locked, lock stays and no capture occurs (stall, no timeout).
REQ-025 Requester SHALL treat grant as consumption of its current beat; req held with grant low SHALL NOT be lost.

Reset
REQ-026 rst SHALL clear out_valid=0, d_out=0, out_src=0, all pri=0, lock=0, lock_idx=0.
REQ-027 rst asserted mid-burst or with out_valid=1 SHALL discard pending beat and lock; grant SHALL be 0 while rst=1.
REQ-028 First capture after reset with all requests high SHALL select requester 0.

Structure
REQ-029 Shared package ast_pkg SHALL hold requester-count/tree-size constants (N, node count) and a clog2 function.
REQ-030 One sub-module ast_node SHALL implement a 2-input node: child actives in, pri flop, select out, update enable; tree generated from instances, leaf level fed by req.
REQ-031 Output register, lock state and capture logic SHALL live in the top level.

Verification (SWITCH_BITS=2, DATA_WIDTH=8, d_in[i]=8'hA0+i unless stated)
REQ-032 Reset, req=4'b1111, req_last=4'b1111, out_ready=1 for 4 cycles -> grants 0001,0100,0010,1000; out_src 0,2,1,3 one cycle later each.
REQ-033 req=4'b0100 only, out_ready=0 -> grant=0100 once, d_out=8'hA2 held, out_valid=1, no further grants until out_ready=1.
REQ-034 req=4'b0011, req_last[0]=0 for 2 beats then 1, out_ready=1 -> grant 0001 x3 consecutive, then 0010.
REQ-035 Lock on req 0 then req[0] dropped 2 cycles with req[1]=1 -> grant=0 both cycles, out_valid clears after drain.
REQ-036 rst pulse while out_valid=1 and locked -> next cycle out_valid=0; req=4'b1111 -> grant=0001.
